// File: rtl/ram_march_tester_if.sv
// Single-port synchronous RAM bus between the march tester (master) and the RAM (slave).
interface ram_march_tester_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    output mem_write_en,
    output mem_addr,
    output mem_data_in,
    input  mem_data_out
  );

  modport slave (
    input  mem_write_en,
    input  mem_addr,
    input  mem_data_in,
    output mem_data_out
  );
endinterface

// File: rtl/ram_march_tester.sv
// Three-phase march BIST for a single-port synchronous RAM; stops at the first
// mismatch and reports address, read data and expected data.
module ram_march_tester #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_expected,
  ram_march_tester_if.master mem
);

  typedef enum logic [2:0] {
    IDLE,
    W_P,
    R_P,
    W_N,
    R_N,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [DATA_W-1:0] pat;
  logic              chk_valid;
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] chk_exp;
  logic              rd_cycle;
  logic              accept;
  logic              mismatch;

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  // The compare is gated by busy so a read registered on the way into DONE is never checked.
  assign mismatch = busy && chk_valid && (mem.mem_data_out != chk_exp);

  always_comb begin
    state_nxt        = state;
    addr_nxt         = addr;
    accept           = 1'b0;
    rd_cycle         = 1'b0;
    mem.mem_write_en = 1'b0;
    mem.mem_addr     = '0;
    mem.mem_data_in  = '0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = W_P;
          addr_nxt  = '0;
        end
      end
      W_P: begin
        mem.mem_write_en = 1'b1;
        mem.mem_addr     = addr;
        mem.mem_data_in  = pat;
        if (addr == LAST) begin
          state_nxt = R_P;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr + ADDR_W'(1);
        end
      end
      R_P: begin
        rd_cycle     = 1'b1;
        mem.mem_addr = addr;
        state_nxt    = W_N;
      end
      W_N: begin
        mem.mem_write_en = 1'b1;
        mem.mem_addr     = addr;
        mem.mem_data_in  = ~pat;
        if (addr == LAST) begin
          state_nxt = R_N;
        end else begin
          state_nxt = R_P;
          addr_nxt  = addr + ADDR_W'(1);
        end
      end
      R_N: begin
        rd_cycle     = 1'b1;
        mem.mem_addr = addr;
        if (addr == '0) begin
          state_nxt = DRAIN;
        end else begin
          addr_nxt = addr - ADDR_W'(1);
        end
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (mismatch) begin
      state_nxt = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      pat           <= '0;
      chk_valid     <= 1'b0;
      chk_addr      <= '0;
      chk_exp       <= '0;
      pass          <= 1'b0;
      fail_addr     <= '0;
      fail_data     <= '0;
      fail_expected <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      chk_valid <= rd_cycle;
      chk_addr  <= addr;
      chk_exp   <= (state == R_N) ? ~pat : pat;
      if (accept) begin
        pat           <= pattern;
        pass          <= 1'b0;
        fail_addr     <= '0;
        fail_data     <= '0;
        fail_expected <= '0;
      end else if (mismatch) begin
        pass          <= 1'b0;
        fail_addr     <= chk_addr;
        fail_data     <= mem.mem_data_out;
        fail_expected <= chk_exp;
      end else if (state == DRAIN) begin
        pass <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_march_tester.sv
// Randomized bench for ram_march_tester: a faulty-RAM model on the bus and an
// operation-list reference model of the march test.
module tb_ram_march_tester;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] pattern = '0;
  logic              busy, done, pass;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data, fail_expected;

  ram_march_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_march_tester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pattern       (pattern),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail_addr     (fail_addr),
    .fail_data     (fail_data),
    .fail_expected (fail_expected),
    .mem           (bus)
  );

  always #5 clk = ~clk;

  // Fault description: 0 none, 1 stuck-at-0 bit, 2 stuck-at-1 bit, 3 coupling f_addr -> f_victim
  int unsigned       fault_kind = 0;
  logic [ADDR_W-1:0] f_addr = '0;
  logic [ADDR_W-1:0] f_victim = '0;
  int unsigned       f_bit = 0;

  function automatic logic [DATA_W-1:0] fault_apply(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    if (fault_kind == 1 && a == f_addr) r[f_bit] = 1'b0;
    if (fault_kind == 2 && a == f_addr) r[f_bit] = 1'b1;
    return r;
  endfunction

  logic [DATA_W-1:0] ram [DEPTH];
  logic              fill = 1'b1;
  int unsigned       total_writes = 0;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= $urandom;
      bus.mem_data_out <= '0;
    end else if (bus.mem_write_en === 1'b1) begin
      ram[bus.mem_addr] <= fault_apply(bus.mem_addr, bus.mem_data_in);
      if (fault_kind == 3 && bus.mem_addr == f_addr)
        ram[f_victim] <= fault_apply(f_victim, bus.mem_data_in);
    end else begin
      bus.mem_data_out <= fault_apply(bus.mem_addr, ram[bus.mem_addr]);
    end
  end

  always @(negedge clk) begin
    if (bus.mem_write_en === 1'b1) total_writes <= total_writes + 1;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [127:0] all_outs();
    return {12'd0, busy, done, pass, fail_addr, fail_data, fail_expected,
            bus.mem_write_en, bus.mem_addr, bus.mem_data_in};
  endfunction

  // Reference model: walks the march operation list on its own copy of the RAM.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              m_pass;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data, m_exp;
  int unsigned       m_done_edge, m_writes;

  task automatic ref_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ref_mem[a] = fault_apply(a, d);
    if (fault_kind == 3 && a == f_addr) ref_mem[f_victim] = fault_apply(f_victim, d);
    m_writes++;
  endtask

  task automatic model_run(input logic [DATA_W-1:0] p);
    logic [DATA_W-1:0] rd;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = ram[i];
    m_pass = 1'b1; m_addr = '0; m_data = '0; m_exp = '0; m_writes = 0;
    m_done_edge = 4 * DEPTH + 1;
    for (int a = 0; a < DEPTH; a++) ref_write(ADDR_W'(a), p);
    for (int a = 0; a < DEPTH; a++) begin
      rd = fault_apply(ADDR_W'(a), ref_mem[a]);
      ref_write(ADDR_W'(a), ~p);
      if (rd !== p) begin
        m_pass = 1'b0; m_addr = ADDR_W'(a); m_data = rd; m_exp = p;
        m_done_edge = DEPTH + 2 * a + 2;
        return;
      end
    end
    for (int a = DEPTH - 1; a >= 0; a--) begin
      rd = fault_apply(ADDR_W'(a), ref_mem[a]);
      if (rd !== ~p) begin
        m_pass = 1'b0; m_addr = ADDR_W'(a); m_data = rd; m_exp = ~p;
        m_done_edge = 3 * DEPTH + (DEPTH - 1 - a) + 2;
        return;
      end
    end
  endtask

  task automatic run_test(input logic [DATA_W-1:0] p, input bit noise, input int abort_at, input string tag);
    int unsigned base, got_edge, edge_n, diffs, w;
    bit          seen;
    @(negedge clk);
    pattern = p;
    start   = 1'b1;
    model_run(p);
    @(posedge clk);
    base = total_writes;
    #1;
    start = 1'b0;
    check({tag, ".busy0"}, 128'(busy), 128'(1));
    check({tag, ".cleared"}, {done, pass, fail_addr, fail_data, fail_expected}, 128'(0));
    edge_n = 0; got_edge = 0; seen = 1'b0;
    while (edge_n < 1100 && !seen) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      if (abort_at >= 0 && edge_n == abort_at) begin
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".abort_outs"}, all_outs(), 128'(0));
        rst = 1'b0;
        w = total_writes;
        repeat (4) @(negedge clk);
        check({tag, ".abort_quiet"}, 128'(total_writes - w), 128'(0));
        check({tag, ".abort_idle"}, all_outs(), 128'(0));
        return;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        got_edge = edge_n;
      end else if (noise) begin
        start   = ($urandom_range(0, 3) == 0);
        pattern = $urandom;
      end
    end
    start = 1'b0;
    check({tag, ".done_edge"}, 128'(got_edge), 128'(m_done_edge));
    check({tag, ".pass"}, 128'(pass), 128'(m_pass));
    check({tag, ".fail_addr"}, 128'(fail_addr), 128'(m_addr));
    check({tag, ".fail_data"}, 128'(fail_data), 128'(m_data));
    check({tag, ".fail_exp"}, 128'(fail_expected), 128'(m_exp));
    check({tag, ".writes"}, 128'(total_writes - base), 128'(m_writes));
    check({tag, ".busy_low"}, 128'(busy), 128'(0));
    check({tag, ".bus_idle"}, {bus.mem_write_en, bus.mem_addr, bus.mem_data_in}, 128'(0));
    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) diffs++;
    check({tag, ".ram_image"}, 128'(diffs), 128'(0));
  endtask

  initial begin
    int unsigned bad;
    rst  = 1'b1;
    fill = 1'b1;
    @(posedge clk);
    #1 fill = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", all_outs(), 128'(0));
    rst = 1'b0;

    fault_kind = 0;
    run_test(32'hA5A5_5A5A, 1'b0, -1, "march_ok");
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== 32'h5A5A_A5A5) bad++;
    check("march_ok.readback", 128'(bad), 128'(0));

    fault_kind = 1; f_addr = 8'h42; f_bit = 3;
    run_test(32'hFFFF_FFFF, 1'b0, -1, "stuck_42");

    fault_kind = 3; f_addr = 8'h10; f_victim = 8'h11;
    run_test(32'h0000_0000, 1'b0, -1, "coupling");

    fault_kind = 1; f_addr = 8'h00; f_bit = 0;
    run_test(32'hFFFF_FFFE, 1'b0, -1, "drain_fail");

    fault_kind = 0;
    run_test($urandom, 1'b0, -1, "restart");
    run_test($urandom, 1'b1, -1, "start_noise");
    run_test($urandom, 1'b0, 300, "abort");
    run_test($urandom, 1'b0, -1, "after_abort");

    for (int r = 0; r < 4; r++) begin
      fault_kind = $urandom_range(0, 3);
      f_addr     = ADDR_W'($urandom);
      f_victim   = f_addr + ADDR_W'($urandom_range(1, DEPTH - 1));
      f_bit      = $urandom_range(0, DATA_W - 1);
      run_test($urandom, r[0], -1, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
